// File: rtl/bitmove_pkg.sv
// bitmove_pkg: shared types and constants for the bit-movement engine.
//   state_t      - engine FSM states
//   REG_*        - descriptor register indices (sAddr[2:0])
//   CHUNK_W      - width of the per-chunk bit count (holds 1..32)
package bitmove_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RS,
        RD,
        WA,
        WD,
        FIN
    } state_t;

    localparam logic [2:0] REG_SRC_WA  = 3'd0;
    localparam logic [2:0] REG_SRC_OFF = 3'd1;
    localparam logic [2:0] REG_DST_WA  = 3'd2;
    localparam logic [2:0] REG_DST_OFF = 3'd3;
    localparam logic [2:0] REG_LEN     = 3'd4;

    localparam int CHUNK_W = 6;

endpackage

// File: rtl/bitmove_engine_if.sv
// bitmove_engine_if: bridge-facing signals of the engine.
//   Register port : sSel, sRW, sAddr, sWdata (bridge -> engine)
//   Master port   : mReq, mRW, mAddr, mWdata (engine -> bridge),
//                   mRdata, mHold (bridge -> engine)
//   Status        : done (engine -> bridge)
// Modport master is the engine's view; slave is the bridge's view.
interface bitmove_engine_if;

    logic        sSel;
    logic        sRW;
    logic [31:0] sAddr;
    logic [31:0] sWdata;
    logic        mReq;
    logic        mRW;
    logic [29:0] mAddr;
    logic [31:0] mWdata;
    logic [31:0] mRdata;
    logic        mHold;
    logic        done;

    modport master (
        input  sSel, sRW, sAddr, sWdata, mRdata, mHold,
        output mReq, mRW, mAddr, mWdata, done
    );

    modport slave (
        output sSel, sRW, sAddr, sWdata, mRdata, mHold,
        input  mReq, mRW, mAddr, mWdata, done
    );

endinterface

// File: rtl/bitmove_merge.sv
// bitmove_merge: combinational chunk sizing and read-modify-write merge.
//   src, dst           - source and destination words
//   src_off, dst_off   - current bit offsets within those words
//   remaining          - bits still to copy
//   n                  - bits moved by this chunk (1..32 while remaining != 0)
//   merged             - dst with n bits at dst_off replaced by src bits at src_off
module bitmove_merge
    import bitmove_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic [31:0]        src,
    input  logic [31:0]        dst,
    input  logic [4:0]         src_off,
    input  logic [4:0]         dst_off,
    input  logic [LEN_W-1:0]   remaining,
    output logic [CHUNK_W-1:0] n,
    output logic [31:0]        merged
);

    logic [CHUNK_W-1:0] room_src;
    logic [CHUNK_W-1:0] room_dst;
    logic [CHUNK_W-1:0] room;
    logic [31:0]        mask;

    always_comb begin
        room_src = CHUNK_W'(32) - CHUNK_W'(src_off);
        room_dst = CHUNK_W'(32) - CHUNK_W'(dst_off);
        room     = (room_src < room_dst) ? room_src : room_dst;
        if (32'(remaining) < 32'(room)) n = CHUNK_W'(remaining);
        else                            n = room;
        // A 32-bit shift by 32 would wrap to 0, so the full word is special-cased.
        mask   = (n == CHUNK_W'(32)) ? 32'hFFFF_FFFF : ((32'd1 << n[4:0]) - 32'd1);
        merged = (dst & ~(mask << dst_off)) | (((src >> src_off) & mask) << dst_off);
    end

endmodule

// File: rtl/bitmove_engine.sv
// bitmove_engine: copies a LEN-bit field from (SRC_WA, SRC_OFF) to
// (DST_WA, DST_OFF) using one read-src / read-dst / write-dst sequence per chunk.
//   HCLK, HRESET - clock, asynchronous active-high reset
//   bus          - bridge register port, word-addressed master port and done pulse
module bitmove_engine
    import bitmove_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int LEN_W  = 16
) (
    input logic              HCLK,
    input logic              HRESET,
    bitmove_engine_if.master bus
);

    state_t             state;
    logic [29:0]        src_wa_r, dst_wa_r, cur_src_wa, cur_dst_wa;
    logic [4:0]         src_off_r, dst_off_r, cur_src_off, cur_dst_off;
    logic [LEN_W-1:0]   len_r, remaining;
    logic [31:0]        src_word, merged;
    logic [CHUNK_W-1:0] n, src_sum, dst_sum;
    logic [LEN_W-1:0]   rem_nx;
    logic [29:0]        src_wa_nx, dst_wa_nx;
    logic [2:0]         reg_idx;
    logic               reg_wr, stall;
    logic               unused_bits;

    assign reg_idx = 3'(bus.sAddr[REG_AW-1:0]);
    assign reg_wr  = bus.sSel && bus.sRW && (state == IDLE);
    assign stall   = bus.mHold && (state inside {RS, RD, WA, WD});

    // The destination word is merged straight off mRdata in its data phase.
    bitmove_merge #(.LEN_W(LEN_W)) u_merge (
        .src       (src_word),
        .dst       (bus.mRdata),
        .src_off   (cur_src_off),
        .dst_off   (cur_dst_off),
        .remaining (remaining),
        .n         (n),
        .merged    (merged)
    );

    // Offset + n never exceeds 32, so the carry bit marks "offset reached 32".
    assign src_sum   = CHUNK_W'(cur_src_off) + n;
    assign dst_sum   = CHUNK_W'(cur_dst_off) + n;
    assign src_wa_nx = cur_src_wa + 30'(src_sum[CHUNK_W-1]);
    assign dst_wa_nx = cur_dst_wa + 30'(dst_sum[CHUNK_W-1]);
    assign rem_nx    = remaining - LEN_W'(n);

    // LEN has no readback path; upper address/data bits are not decoded.
    assign unused_bits = ^{bus.sAddr[31:REG_AW], bus.sWdata[31:30], len_r};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= IDLE;
            src_wa_r    <= '0;
            src_off_r   <= '0;
            dst_wa_r    <= '0;
            dst_off_r   <= '0;
            len_r       <= '0;
            cur_src_wa  <= '0;
            cur_src_off <= '0;
            cur_dst_wa  <= '0;
            cur_dst_off <= '0;
            remaining   <= '0;
            src_word    <= '0;
            bus.mReq    <= 1'b0;
            bus.mRW     <= 1'b0;
            bus.mAddr   <= '0;
            bus.mWdata  <= '0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (!stall) begin
                case (state)
                    IDLE: if (reg_wr) begin
                        case (reg_idx)
                            REG_SRC_WA:  src_wa_r  <= bus.sWdata[29:0];
                            REG_SRC_OFF: src_off_r <= bus.sWdata[4:0];
                            REG_DST_WA:  dst_wa_r  <= bus.sWdata[29:0];
                            REG_DST_OFF: dst_off_r <= bus.sWdata[4:0];
                            REG_LEN: begin
                                len_r       <= bus.sWdata[LEN_W-1:0];
                                remaining   <= bus.sWdata[LEN_W-1:0];
                                cur_src_wa  <= src_wa_r;
                                cur_src_off <= src_off_r;
                                cur_dst_wa  <= dst_wa_r;
                                cur_dst_off <= dst_off_r;
                                if (bus.sWdata[LEN_W-1:0] == '0) begin
                                    state    <= FIN;
                                    bus.done <= 1'b1;
                                end else begin
                                    state     <= RS;
                                    bus.mReq  <= 1'b1;
                                    bus.mRW   <= 1'b0;
                                    bus.mAddr <= src_wa_r;
                                end
                            end
                            default: ;
                        endcase
                    end
                    RS: begin
                        state     <= RD;
                        bus.mAddr <= cur_dst_wa;
                    end
                    RD: begin
                        src_word <= bus.mRdata;
                        state    <= WA;
                        bus.mRW  <= 1'b1;
                    end
                    WA: begin
                        bus.mWdata <= merged;
                        bus.mReq   <= 1'b0;
                        state      <= WD;
                    end
                    WD: begin
                        remaining   <= rem_nx;
                        cur_src_off <= src_sum[4:0];
                        cur_dst_off <= dst_sum[4:0];
                        cur_src_wa  <= src_wa_nx;
                        cur_dst_wa  <= dst_wa_nx;
                        bus.mRW     <= 1'b0;
                        if (rem_nx == '0) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state     <= RS;
                            bus.mReq  <= 1'b1;
                            bus.mAddr <= src_wa_nx;
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/bitmove_engine.md
# bitmove_engine

Bit-movement engine core fed by the AHB descriptor bridge. It accepts a five-word descriptor through the bridge's register-write port and copies an arbitrary-length bit field from a source word address and bit offset to a destination word address and bit offset. It uses the bridge's word-addressed master port with one read-modify-write sequence per chunk, and pulses `done` when the copy completes.

## Interface
- `REG_AW`, 3: register index bits decoded from `sAddr`.
- `LEN_W`, 16: width of the bit-length register.
- `HCLK` in 1: clock; all state changes on its rising edge.
- `HRESET` in 1: reset, asynchronous and active-high.
- `sSel` in 1: register access strobe from the bridge.
- `sRW` in 1: 1 = write. Reads are ignored.
- `sAddr` in 32: register index; only `[REG_AW-1:0]` is decoded.
- `sWdata` in 32: register write data.
- `mReq` out 1: master transfer request (address phase).
- `mRW` out 1: 1 = write, 0 = read.
- `mAddr` out 30: word address. The bridge appends `2'b00`.
- `mWdata` out 32: write data, valid in the data phase.
- `mRdata` in 32: read data, valid in the data phase.
- `mHold` in 1: bus not granted; the FSM freezes.
- `done` out 1: one-cycle completion pulse.

## Operation
- Registers, indexed by `sAddr[2:0]`:
  - 0 `SRC_WA[29:0]`
  - 1 `SRC_OFF[4:0]`
  - 2 `DST_WA[29:0]`
  - 3 `DST_OFF[4:0]`
  - 4 `LEN[15:0]`; a write to it starts the copy.
  - Indices 5–7 are ignored.
- Register writes are accepted only in IDLE; writes while busy are dropped, including to `LEN`.
- Bit 0 is the LSB of each word.
- Chunk size, 6-bit unsigned: `n = min(32-src_off, 32-dst_off, remaining)`. `n` is always between 1 and 32.
- Mask = `(n==32) ? 32'hFFFF_FFFF : (1<<n)-1`. Do not compute it as a 32-bit shift of 32.
- Merge: `new = (dst & ~(mask<<dst_off)) | (((src>>src_off) & mask) << dst_off)`.
- After each chunk, in all cases: `remaining -= n`; `src_off += n`; `dst_off += n`.
- After each chunk, in either register:
  - If the offset reaches 32, set it to 0 and increment the word address.
  - Word addresses wrap modulo 2^30.
- FSM states:
  - IDLE: on a `LEN` write, load working copies. `LEN==0` → FIN, otherwise → RS.
  - RS: issue a read of the source word → RD.
  - RD: capture the source word from `mRdata`; issue a read of the destination word → WA.
  - WA: capture the destination word; issue a write to the destination word → WD.
  - WD: drive the merged word on `mWdata`; update counters. If remaining is 0 → FIN, else → RS.
  - FIN: `done`=1 → IDLE.
- `mHold`=1 in RS, RD, WA or WD:
  - The state, `mReq`, `mRW`, `mAddr` and `mWdata` hold their values.
  - No data is captured and no counter is updated.
  - The same state is retried when `mHold` falls.
- Descriptor registers keep their last values after completion.

## Timing
- A transfer issues in cycle N when `mReq`=1 and `mHold`=0.
  - Read data is sampled from `mRdata` in cycle N+1.
  - Write data is driven on `mWdata` in cycle N+1.
- `mReq`=1 only in RS, RD and WA.
- Each chunk takes 4 cycles without hold.
- Start to `done`: `4*chunks + 2` cycles, counted from the `LEN` write edge to the `done` cycle inclusive.
- `done` is a registered one-cycle pulse and is never high in IDLE.
  - The bridge may poll `done` in the cycle its `LEN` write is presented and must see 0.
- Reset mid-copy:
  - Return to IDLE immediately.
  - All registers are cleared.
  - The partially written destination is left as-is.
- Reset values of outputs: `mReq`=0, `mRW`=0, `mAddr`=0, `mWdata`=0, `done`=0. All registers reset to 0.

## Structure
- `bitmove_pkg` holds:
  - the FSM state enum;
  - register index constants `REG_SRC_WA`…`REG_LEN`;
  - the chunk-width constant 6.
- Sub-module `bitmove_merge` is purely combinational:
  - inputs: src, dst, src_off, dst_off, remaining;
  - outputs: n, merged word.
- The top level holds the register file, the FSM and the counters.

## Test plan
- Single in-word chunk: SRC 0x10 off 4, DST 0x20 off 0, LEN 8, mem[0x10]=0x0000_0AB0, mem[0x20]=0xFFFF_FFFF → mem[0x20]=0xFFFF_FFAB; `done` after 6 cycles.
- Source crosses a word: SRC off 28, LEN 8, mem[0x10]=0xA000_0000, mem[0x11]=0x0000_000B, DST 0x20 off 0, initial 0 → mem[0x20]=0x0000_00BA; two chunks; `done` at cycle 10.
- Full word: both offsets 0, LEN 32, src 0xDEAD_BEEF → destination exactly 0xDEAD_BEEF; mask has no overflow.
- LEN 0 → no `mReq`; `done` pulse 2 cycles after the write.
- `mHold` asserted for 3 cycles in RD and again in WD → address and data stay stable; result identical to the unheld run; latency +6.
- Write SRC_WA while busy, then assert `HRESET` mid-copy → the write has no effect; after reset `mReq`=0, `done`=0, and a new descriptor runs correctly.
